// File: rtl/mips_run_ctrl.sv
// Run controller for pipe_MIPS32: load image, init core, run until HLT/watchdog, dump registers.
// Optional single-step gating of the core clock-enable when MIPS_RUN_CTRL_STEP_EN is defined.
module mips_run_ctrl #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned DUMP_REGS  = 6
) (
`ifdef MIPS_RUN_CTRL_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_init,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {StIdle, StLoad, StInit, StRun, StDump, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic                timeout_q, timeout_d;
    logic                run_en;
    logic [CNT_W-1:0]    cnt_inc;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            idx_q     <= '0;
            cycle_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            cycle_q   <= cycle_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef MIPS_RUN_CTRL_STEP_EN
    assign run_en = !step_mode || step;
`else
    assign run_en = 1'b1;
`endif

    assign cnt_inc     = cycle_q + 1'b1;
    assign cycle_count = cycle_q;
    assign timeout     = timeout_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        cycle_d    = cycle_q;
        timeout_d  = timeout_q;
        ld_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_init   = 1'b0;
        cpu_run    = 1'b0;
        reg_raddr  = '0;
        dump_valid = 1'b0;
        dump_idx   = '0;
        dump_data  = '0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    state_d   = StLoad;
                    addr_d    = '0;
                    timeout_d = 1'b0;
                    cycle_d   = '0;
                end
            end
            StLoad: begin
                busy      = 1'b1;
                ld_ready  = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = ld_data;
                if (ld_valid) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    // Accepting the top address ends the load; the wrapped address is never written.
                    if (ld_last || (addr_q == '1)) begin
                        state_d = StInit;
                    end
                end
            end
            StInit: begin
                busy     = 1'b1;
                cpu_init = 1'b1;
                cycle_d  = '0;
                idx_d    = '0;
                state_d  = StRun;
            end
            StRun: begin
                busy    = 1'b1;
                cpu_run = run_en;
                if (run_en) begin
                    cycle_d = cnt_inc;
                end
                // Halt takes priority over the watchdog in the same cycle.
                if (cpu_halted) begin
                    state_d = StDump;
                end else if (run_en && (cnt_inc >= CNT_W'(MAX_CYCLES))) begin
                    timeout_d = 1'b1;
                    state_d   = StDump;
                end
            end
            StDump: begin
                busy       = 1'b1;
                reg_raddr  = idx_q;
                dump_valid = 1'b1;
                dump_idx   = idx_q;
                dump_data  = reg_rdata;
                if (dump_ready) begin
                    if (idx_q == 5'(DUMP_REGS - 1)) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
